// File: rtl/calc_pkg.sv
// Shared types for the sequential calculator: operation modes, controller states
// and the default operand width.
package calc_pkg;

    localparam int DEFAULT_WIDTH = 6;

    typedef enum logic [1:0] {
        MODE_HARM = 2'd0,
        MODE_MUL  = 2'd1,
        MODE_ADD  = 2'd2,
        MODE_DIV  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/calc_seq_unit_divider.sv
// Restoring divider, one quotient bit per clock. quotient/remainder show the result
// of the step about to be clocked, so they hold the final values while done is high.
module seq_divider #(
    parameter int OW = 2 * calc_pkg::DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [OW-1:0] dividend,
    input  logic [OW-1:0] divisor,
    output logic          done,
    output logic [OW-1:0] quotient,
    output logic [OW-1:0] remainder,
    output logic          dz
);

    localparam int CW = $clog2(OW);

    logic [OW-1:0] rem_q;
    logic [OW-1:0] quo_q;
    logic [OW-1:0] dvsr_q;
    logic [CW-1:0] count_q;
    logic          running_q;
    logic [OW:0]   rem_shift;
    logic [OW-1:0] trial;

    // The partial remainder is always below the divisor, so the shifted value needs
    // one extra bit and the difference always fits back into OW bits.
    always_comb begin
        rem_shift = {rem_q, quo_q[OW-1]};
        trial     = rem_shift[OW-1:0] - dvsr_q;
        quotient  = {quo_q[OW-2:0], 1'b0};
        remainder = rem_shift[OW-1:0];
        if (rem_shift >= {1'b0, dvsr_q}) begin
            quotient  = {quo_q[OW-2:0], 1'b1};
            remainder = trial;
        end
    end

    assign done = running_q && (count_q == CW'(OW - 1));
    assign dz   = (divisor == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            count_q   <= '0;
            running_q <= 1'b0;
        end else if (start) begin
            rem_q     <= '0;
            quo_q     <= dividend;
            dvsr_q    <= divisor;
            count_q   <= '0;
            running_q <= 1'b1;
        end else if (running_q) begin
            rem_q   <= remainder;
            quo_q   <= quotient;
            count_q <= count_q + 1'b1;
            if (done) begin
                running_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/calc_seq_unit.sv
// Sequential calculator: harmonic-style (a*b)/(a+b), multiply, add or divide using an
// inline shift-add multiplier and seq_divider. Define CALC_DIV_ROUND_EN to round quotients half up.
module calc_seq_unit
    import calc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     num1,
    input  logic [WIDTH-1:0]     num2,
    input  logic [1:0]           mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   answer,
    output logic [2*WIDTH-1:0]   residue,
    output logic [2*WIDTH-1:0]   ans1,
    output logic [WIDTH:0]       ans2,
    output logic                 div_by_zero,
    output logic                 busy
);

    localparam int OW  = 2 * WIDTH;
    localparam int MCW = $clog2(WIDTH + 1);

    state_t           state;
    mode_t            mode_q;
    logic [OW-1:0]    acc;
    logic [OW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [MCW-1:0]   mul_count;
    logic [OW-1:0]    product_next;
    logic             mul_last;
    logic [WIDTH:0]   sum_in;

    logic             div_start;
    logic [OW-1:0]    div_dividend;
    logic [OW-1:0]    div_divisor;
    logic             div_done;
    logic [OW-1:0]    div_quotient;
    logic [OW-1:0]    div_remainder;
    logic             div_dz;
    logic [OW-1:0]    div_answer;

    assign sum_in       = {1'b0, num1} + {1'b0, num2};
    assign product_next = acc + (mplier[0] ? mcand : '0);
    assign mul_last     = (mul_count == MCW'(WIDTH - 1));

    // Operands reach the divider straight from the ports for a DIV accept, and from the
    // finishing product and registered sum when a HARM multiply hands over.
    always_comb begin
        div_dividend = product_next;
        div_divisor  = OW'(ans2);
        div_start    = 1'b0;
        if (state == IDLE) begin
            div_dividend = OW'(num1);
            div_divisor  = OW'(num2);
            div_start    = in_valid && (mode_t'(mode) == MODE_DIV);
        end else if (state == MUL) begin
            div_start = mul_last && (mode_q == MODE_HARM);
        end
    end

    seq_divider #(
        .OW(OW)
    ) u_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .done      (div_done),
        .quotient  (div_quotient),
        .remainder (div_remainder),
        .dz        (div_dz)
    );

`ifdef CALC_DIV_ROUND_EN
    logic [OW-1:0] dvsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dvsr_q <= '0;
        end else if (div_start) begin
            dvsr_q <= div_divisor;
        end
    end

    assign div_answer = ({div_remainder, 1'b0} >= {1'b0, dvsr_q}) ? div_quotient + 1'b1
                                                                  : div_quotient;
`else
    assign div_answer = div_quotient;
`endif

    // ADD and a zero-divisor DIV land in DONE with out_valid still low; the first DONE
    // edge raises it, giving them one cycle of latency like the other short paths.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mode_q      <= MODE_HARM;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            mul_count   <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            answer      <= '0;
            residue     <= '0;
            ans1        <= '0;
            ans2        <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mode_q      <= mode_t'(mode);
                        ans2        <= sum_in;
                        answer      <= '0;
                        residue     <= '0;
                        ans1        <= '0;
                        div_by_zero <= 1'b0;
                        acc         <= '0;
                        mcand       <= OW'(num1);
                        mplier      <= num2;
                        mul_count   <= '0;
                        in_ready    <= 1'b0;
                        case (mode_t'(mode))
                            MODE_HARM, MODE_MUL: begin
                                state <= MUL;
                                busy  <= 1'b1;
                            end
                            MODE_ADD: begin
                                state  <= DONE;
                                answer <= OW'(sum_in);
                            end
                            default: begin
                                if (div_dz) begin
                                    state       <= DONE;
                                    answer      <= '1;
                                    residue     <= OW'(num1);
                                    div_by_zero <= 1'b1;
                                end else begin
                                    state <= DIV;
                                    busy  <= 1'b1;
                                end
                            end
                        endcase
                    end
                end

                MUL: begin
                    acc       <= product_next;
                    mcand     <= mcand << 1;
                    mplier    <= mplier >> 1;
                    mul_count <= mul_count + 1'b1;
                    if (mul_last) begin
                        ans1 <= product_next;
                        if (mode_q == MODE_HARM && !div_dz) begin
                            state <= DIV;
                        end else begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                            if (mode_q == MODE_HARM) begin
                                answer      <= '1;
                                residue     <= product_next;
                                div_by_zero <= 1'b1;
                            end else begin
                                answer <= product_next;
                            end
                        end
                    end
                end

                DIV: begin
                    if (div_done) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        answer    <= div_answer;
                        residue   <= div_remainder;
                    end
                end

                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_seq_unit.sv
// Directed and randomised checks of calc_seq_unit against a scoreboard of expected
// results built from plain integer arithmetic.
module tb_calc_seq_unit;

    localparam int W   = 6;
    localparam int OW  = 2 * W;
    localparam int ONES = (1 << OW) - 1;

    typedef struct {
        string tag;
        int    answer;
        int    residue;
        int    ans1;
        int    ans2;
        int    dz;
        int    lat;
        int    busy;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      num1;
    logic [W-1:0]      num2;
    logic [1:0]        mode;
    logic              out_valid;
    logic              out_ready;
    logic [OW-1:0]     answer;
    logic [OW-1:0]     residue;
    logic [OW-1:0]     ans1;
    logic [W:0]        ans2;
    logic              div_by_zero;
    logic              busy;

    int   n_vec = 0;
    int   n_miss = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    exp_t exp_q[$];

    calc_seq_unit #(
        .WIDTH(W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .num1        (num1),
        .num2        (num2),
        .mode        (mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .answer      (answer),
        .residue     (residue),
        .ans1        (ans1),
        .ans2        (ans2),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_miss++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input int m, input int a, input int b, input string tag);
        exp_t e;
        int   p;
        int   s;
        int   d;
        p = a * b;
        s = a + b;
        d = 0;
        e.tag = tag;
        e.ans2 = s;
        e.ans1 = 0;
        e.residue = 0;
        e.dz = 0;
        e.busy = 1;
        case (m)
            0: begin
                e.ans1 = p;
                if (s == 0) begin
                    e.answer = ONES; e.residue = p; e.dz = 1; e.lat = W;
                end else begin
                    e.answer = p / s; e.residue = p % s; d = s; e.lat = W + OW;
                end
            end
            1: begin
                e.ans1 = p; e.answer = p; e.lat = W;
            end
            2: begin
                e.answer = s; e.lat = 1; e.busy = 0;
            end
            default: begin
                if (b == 0) begin
                    e.answer = ONES; e.residue = a; e.dz = 1; e.lat = 1; e.busy = 0;
                end else begin
                    e.answer = a / b; e.residue = a % b; d = b; e.lat = OW;
                end
            end
        endcase
`ifdef CALC_DIV_ROUND_EN
        if (d != 0 && 2 * e.residue >= d) e.answer = e.answer + 1;
`endif
        return e;
    endfunction

    task automatic applyStimulus(input int m, input int a, input int b, input string tag);
        exp_t e;
        int   guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
        mode = 2'(m);
        num1 = W'(a);
        num2 = W'(b);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        acc_cyc = cyc;
        e = model(m, a, b, tag);
        exp_q.push_back(e);
        checkOutput({tag, " busy after accept"}, 32'(busy), 32'(e.busy));
        checkOutput({tag, " in_ready after accept"}, 32'(in_ready), 32'd0);
    endtask

    task automatic collectResult(input int hold);
        exp_t e;
        int   guard;
        e = exp_q.pop_front();
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({e.tag, " out_valid arrives"}, 32'(out_valid), 32'd1);
        checkOutput({e.tag, " latency"}, 32'(cyc - acc_cyc), 32'(e.lat));
        checkOutput({e.tag, " answer"}, 32'(answer), 32'(e.answer));
        checkOutput({e.tag, " residue"}, 32'(residue), 32'(e.residue));
        checkOutput({e.tag, " ans1"}, 32'(ans1), 32'(e.ans1));
        checkOutput({e.tag, " ans2"}, 32'(ans2), 32'(e.ans2));
        checkOutput({e.tag, " div_by_zero"}, 32'(div_by_zero), 32'(e.dz));
        checkOutput({e.tag, " busy in done"}, 32'(busy), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput({e.tag, " held out_valid"}, 32'(out_valid), 32'd1);
            checkOutput({e.tag, " held answer"}, 32'(answer), 32'(e.answer));
            checkOutput({e.tag, " held in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({e.tag, " out_valid cleared"}, 32'(out_valid), 32'd0);
        checkOutput({e.tag, " in_ready restored"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        exp_t dropped;
        int   m;
        int   a;
        int   b;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        num1 = '0;
        num2 = '0;
        mode = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset answer", 32'(answer), 32'd0);
        checkOutput("reset residue", 32'(residue), 32'd0);
        checkOutput("reset ans1", 32'(ans1), 32'd0);
        checkOutput("reset ans2", 32'(ans2), 32'd0);
        checkOutput("reset div_by_zero", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed operations");
        applyStimulus(0, 6, 3, "harm 6,3");
        collectResult(0);
        applyStimulus(0, 63, 63, "harm 63,63");
        collectResult(0);
        applyStimulus(0, 0, 0, "harm 0,0");
        collectResult(0);
        applyStimulus(3, 50, 0, "div 50/0");
        collectResult(0);

        // Junk requests while busy must be ignored.
        applyStimulus(3, 50, 7, "div 50/7");
        in_valid = 1'b1;
        mode = 2'd1;
        num1 = 6'd1;
        num2 = 6'd1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        collectResult(0);

        applyStimulus(2, 63, 63, "add 63,63");
        collectResult(0);

        $display("[TB] backpressure and back-to-back");
        applyStimulus(1, 9, 7, "mul 9*7");
        collectResult(5);
        applyStimulus(1, 63, 63, "mul 63*63");
        collectResult(1);

        $display("[TB] reset mid-operation");
        applyStimulus(0, 20, 10, "harm aborted");
        dropped = exp_q.pop_back();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort in_ready", 32'(in_ready), 32'd1);
        checkOutput("abort busy", 32'(busy), 32'd0);
        rst = 1'b0;
        applyStimulus(0, 13, 5, "harm 13,5 after abort");
        collectResult(0);

        $display("[TB] random operations");
        for (int i = 0; i < 10; i++) begin
            m = int'($urandom_range(0, 3));
            a = int'($urandom_range(0, 63));
            b = int'($urandom_range(0, 63));
            if (i == 0) b = 0;
            applyStimulus(m, a, b, $sformatf("rand%0d m%0d %0d,%0d", i, m, a, b));
            collectResult(i % 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
